// File: rtl/wr_bus_arb_pkg.sv
// Shared types and helpers for the write-bus arbiter.
package wr_bus_arb_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    GRANTED = 1'b1
  } state_t;

  localparam int ERR_CNT_W = 8;

  // Width of an owner index; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/wr_bus_arbiter_rr_picker.sv
// Combinational round-robin search: first asserted request strictly after rr_last.
module rr_picker
  import wr_bus_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = idx_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   rr_last,
  output logic               valid,
  output logic [IDX_W-1:0]   sel
);

  always_comb begin
    int k;
    valid = 1'b0;
    sel   = '0;
    k     = 0;
    for (int d = 1; d <= NUM_REQ; d++) begin
      k = (int'(rr_last) + d) % NUM_REQ;
      if (!valid && req[IDX_W'(k)]) begin
        valid = 1'b1;
        sel   = IDX_W'(k);
      end
    end
  end

endmodule

// File: rtl/wr_bus_arbiter.sv
// Round-robin arbiter sharing one write bus between NUM_REQ requesters,
// with an address window guard on writes and a bounded hold time.
//
// state   | meaning
// IDLE    | no owner, bus outputs driven to zero
// GRANTED | rr_last owns the bus; its ce/wr/addr/data are registered onto the bus
module wr_bus_arbiter
  import wr_bus_arb_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 8,
  parameter int ADDR_MIN = 0,
  parameter int ADDR_MAX = 255,
  parameter int MAX_HOLD = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req,
  output logic [NUM_REQ-1:0]        gnt,
  input  logic [NUM_REQ-1:0]        ce_i,
  input  logic [NUM_REQ-1:0]        wr_i,
  input  logic [NUM_REQ*ADDR_W-1:0] addr_i,
  input  logic [NUM_REQ*DATA_W-1:0] data_i,
  output logic                      ce_o,
  output logic                      wr_o,
  output logic [ADDR_W-1:0]         addr_o,
  output logic [DATA_W-1:0]         data_o,
  output logic                      range_err,
  output logic                      preempt,
  output logic [ERR_CNT_W-1:0]      err_cnt
);

  localparam int IDX_W  = idx_w(NUM_REQ);
  localparam int HOLD_W = $clog2(MAX_HOLD + 2);
  localparam int SPAN   = ADDR_MAX - ADDR_MIN;
  localparam logic [ADDR_W:0]     WIN_LO   = ADDR_MIN[ADDR_W:0];
  localparam logic [ADDR_W:0]     WIN_SPAN = SPAN[ADDR_W:0];
  localparam logic [NUM_REQ-1:0]  REQ_ONE  = {{(NUM_REQ-1){1'b0}}, 1'b1};

  typedef logic [IDX_W-1:0] idx_t;

  state_t                 state, state_n;
  idx_t                   rr_last, rr_last_n;   // doubles as the owner index while GRANTED
  logic [HOLD_W-1:0]      hold_cnt, hold_cnt_n;
  logic [NUM_REQ-1:0]     gnt_n;
  logic                   ce_n, wr_n, range_err_n, preempt_n;
  logic [ADDR_W-1:0]      addr_n;
  logic [DATA_W-1:0]      data_n;
  logic [ERR_CNT_W-1:0]   err_cnt_n;

  logic [ADDR_W-1:0]      addr_arr [NUM_REQ];
  logic [DATA_W-1:0]      data_arr [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign addr_arr[g] = addr_i[g*ADDR_W +: ADDR_W];
    assign data_arr[g] = data_i[g*DATA_W +: DATA_W];
  end

  logic [NUM_REQ-1:0] owner_mask, pick_req;
  logic               pick_valid;
  idx_t               pick_sel;
  logic [ADDR_W-1:0]  own_addr;
  logic [ADDR_W:0]    addr_off;
  logic               in_window, hold_expired;

  assign owner_mask = REQ_ONE << rr_last;
  assign pick_req   = (state == GRANTED) ? (req & ~owner_mask) : req;

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_picker (
    .req     (pick_req),
    .rr_last (rr_last),
    .valid   (pick_valid),
    .sel     (pick_sel)
  );

  // Offset from the window base wraps high for addresses below ADDR_MIN,
  // so a single unsigned compare covers both bounds.
  assign own_addr     = addr_arr[rr_last];
  assign addr_off     = {1'b0, own_addr} - WIN_LO;
  assign in_window    = (addr_off <= WIN_SPAN);
  assign hold_expired = (MAX_HOLD != 0) && (int'(hold_cnt) >= MAX_HOLD - 1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      rr_last   <= idx_t'(NUM_REQ - 1);
      hold_cnt  <= '0;
      gnt       <= '0;
      ce_o      <= 1'b0;
      wr_o      <= 1'b0;
      addr_o    <= '0;
      data_o    <= '0;
      range_err <= 1'b0;
      preempt   <= 1'b0;
      err_cnt   <= '0;
    end else begin
      state     <= state_n;
      rr_last   <= rr_last_n;
      hold_cnt  <= hold_cnt_n;
      gnt       <= gnt_n;
      ce_o      <= ce_n;
      wr_o      <= wr_n;
      addr_o    <= addr_n;
      data_o    <= data_n;
      range_err <= range_err_n;
      preempt   <= preempt_n;
      err_cnt   <= err_cnt_n;
    end
  end

  always_comb begin
    state_n     = state;
    rr_last_n   = rr_last;
    hold_cnt_n  = hold_cnt;
    gnt_n       = gnt;
    ce_n        = 1'b0;
    wr_n        = 1'b0;
    addr_n      = '0;
    data_n      = '0;
    range_err_n = 1'b0;
    preempt_n   = 1'b0;
    err_cnt_n   = err_cnt;

    case (state)
      IDLE: begin
        gnt_n = '0;
        if (pick_valid) begin
          state_n    = GRANTED;
          rr_last_n  = pick_sel;
          hold_cnt_n = '0;
          gnt_n      = REQ_ONE << pick_sel;
        end
      end

      GRANTED: begin
        addr_n = own_addr;
        data_n = data_arr[rr_last];
        if (ce_i[rr_last] && wr_i[rr_last] && !in_window) begin
          range_err_n = 1'b1;
          if (err_cnt != '1) err_cnt_n = err_cnt + 1'b1;
        end else begin
          ce_n = ce_i[rr_last];
          wr_n = wr_i[rr_last];
        end

        if (!req[rr_last]) begin
          if (pick_valid) begin
            rr_last_n  = pick_sel;
            hold_cnt_n = '0;
            gnt_n      = REQ_ONE << pick_sel;
          end else begin
            state_n = IDLE;
            gnt_n   = '0;
          end
        end else if (hold_expired && pick_valid) begin
          preempt_n  = 1'b1;
          rr_last_n  = pick_sel;
          hold_cnt_n = '0;
          gnt_n      = REQ_ONE << pick_sel;
        end else if (hold_cnt != '1) begin
          hold_cnt_n = hold_cnt + 1'b1;
        end
      end

      default: begin
        state_n = IDLE;
        gnt_n   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_wr_bus_arbiter.sv
// Self-checking bench for wr_bus_arbiter: directed vectors plus random traffic
// compared every cycle against an integer-level reference model.
module tb_wr_bus_arbiter;

  localparam int N    = 4;
  localparam int AW   = 8;
  localparam int DW   = 8;
  localparam int AMIN = 1;
  localparam int AMAX = 5;
  localparam int MH   = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req, gnt, ce_i, wr_i;
  logic [AW-1:0]   a_arr [N];
  logic [DW-1:0]   d_arr [N];
  logic [N*AW-1:0] addr_i;
  logic [N*DW-1:0] data_i;
  logic            ce_o, wr_o, range_err, preempt;
  logic [AW-1:0]   addr_o;
  logic [DW-1:0]   data_o;
  logic [7:0]      err_cnt;

  assign addr_i = {a_arr[3], a_arr[2], a_arr[1], a_arr[0]};
  assign data_i = {d_arr[3], d_arr[2], d_arr[1], d_arr[0]};

  always #5 clk = ~clk;

  wr_bus_arbiter #(
    .NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW),
    .ADDR_MIN(AMIN), .ADDR_MAX(AMAX), .MAX_HOLD(MH)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .gnt(gnt),
    .ce_i(ce_i), .wr_i(wr_i), .addr_i(addr_i), .data_i(data_i),
    .ce_o(ce_o), .wr_o(wr_o), .addr_o(addr_o), .data_o(data_o),
    .range_err(range_err), .preempt(preempt), .err_cnt(err_cnt)
  );

  int pass_cnt = 0;
  int total_cnt = 0;

  // Reference model: owner is -1 when the bus is free.
  int           m_owner, m_last, m_hold;
  logic [N-1:0] e_gnt;
  logic         e_ce, e_wr, e_re, e_pre;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_data;
  int           e_err;

  typedef struct {
    logic          ce;
    logic          wr;
    logic [AW-1:0] addr;
    logic          exp_ce;
    logic          exp_wr;
    logic          exp_re;
  } vec_t;

  vec_t vecs [11];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act !== exp)
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    else
      pass_cnt++;
  endtask

  function automatic int next_rr(input int last, input int excl);
    for (int d = 1; d <= N; d++) begin
      int k;
      k = (last + d) % N;
      if (k != excl && req[k]) return k;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_owner = -1; m_last = N - 1; m_hold = 0;
    e_gnt = '0; e_ce = 0; e_wr = 0; e_re = 0; e_pre = 0;
    e_addr = '0; e_data = '0; e_err = 0;
  endtask

  task automatic grant(input int n);
    m_owner = n; m_last = n; m_hold = 0;
  endtask

  task automatic model_step();
    int n;
    logic [AW-1:0] a;
    if (m_owner >= 0) begin
      a = a_arr[m_owner];
      e_addr = a;
      e_data = d_arr[m_owner];
      if (ce_i[m_owner] && wr_i[m_owner] && (a < AMIN || a > AMAX)) begin
        e_ce = 0; e_wr = 0; e_re = 1;
        if (e_err < 255) e_err++;
      end else begin
        e_ce = ce_i[m_owner]; e_wr = wr_i[m_owner]; e_re = 0;
      end
    end else begin
      e_ce = 0; e_wr = 0; e_re = 0; e_addr = '0; e_data = '0;
    end
    e_pre = 0;
    if (m_owner < 0) begin
      n = next_rr(m_last, -1);
      if (n >= 0) grant(n);
    end else if (!req[m_owner]) begin
      n = next_rr(m_owner, -1);
      if (n >= 0) grant(n);
      else m_owner = -1;
    end else begin
      n = next_rr(m_owner, m_owner);
      if (m_hold >= MH - 1 && n >= 0) begin
        e_pre = 1;
        grant(n);
      end else begin
        m_hold++;
      end
    end
    e_gnt = '0;
    if (m_owner >= 0) e_gnt[m_owner] = 1'b1;
  endtask

  task automatic tick(input string tag);
    model_step();
    @(posedge clk);
    #1;
    check({tag, "_gnt"}, gnt, e_gnt);
    check({tag, "_onehot"}, $onehot0(gnt), 1);
    check({tag, "_bus"}, {ce_o, wr_o, addr_o, data_o}, {e_ce, e_wr, e_addr, e_data});
    check({tag, "_flags"}, {range_err, preempt, err_cnt}, {e_re, e_pre, 8'(e_err)});
  endtask

  task automatic quiet_inputs();
    req = '0; ce_i = '0; wr_i = '0;
    for (int i = 0; i < N; i++) begin
      a_arr[i] = '0; d_arr[i] = '0;
    end
  endtask

  task automatic do_reset();
    #2 rst = 1'b1;
    @(posedge clk);
    #3 rst = 1'b0;
    model_reset();
  endtask

  initial begin
    vecs[0]  = '{1'b1, 1'b1, 8'd0,   1'b0, 1'b0, 1'b1};
    vecs[1]  = '{1'b1, 1'b1, 8'd1,   1'b1, 1'b1, 1'b0};
    vecs[2]  = '{1'b1, 1'b1, 8'd2,   1'b1, 1'b1, 1'b0};
    vecs[3]  = '{1'b1, 1'b1, 8'd3,   1'b1, 1'b1, 1'b0};
    vecs[4]  = '{1'b1, 1'b1, 8'd4,   1'b1, 1'b1, 1'b0};
    vecs[5]  = '{1'b1, 1'b1, 8'd5,   1'b1, 1'b1, 1'b0};
    vecs[6]  = '{1'b1, 1'b1, 8'd6,   1'b0, 1'b0, 1'b1};
    vecs[7]  = '{1'b1, 1'b1, 8'd7,   1'b0, 1'b0, 1'b1};
    vecs[8]  = '{1'b1, 1'b1, 8'd8,   1'b0, 1'b0, 1'b1};
    vecs[9]  = '{1'b1, 1'b1, 8'd9,   1'b0, 1'b0, 1'b1};
    vecs[10] = '{1'b1, 1'b0, 8'd200, 1'b1, 1'b0, 1'b0};

    rst = 1'b1;
    quiet_inputs();
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", {gnt, ce_o, wr_o, addr_o, data_o, range_err, preempt, err_cnt}, '0);
    #3 rst = 1'b0;

    // Single requester: 1-cycle grant latency, then the address sweep.
    req = 4'b0001;
    tick("single_req");
    check("grant_latency", gnt, 4'b0001);
    for (int i = 0; i < 11; i++) begin
      ce_i[0] = vecs[i].ce;
      wr_i[0] = vecs[i].wr;
      a_arr[0] = vecs[i].addr;
      d_arr[0] = 8'hA0 + 8'(i);
      tick("sweep");
      check($sformatf("vec%0d", i), {ce_o, wr_o, range_err, addr_o},
            {vecs[i].exp_ce, vecs[i].exp_wr, vecs[i].exp_re, vecs[i].addr});
    end
    check("err_cnt_sweep", err_cnt, 8'd5);
    quiet_inputs();
    tick("release");
    check("release_gnt", gnt, 4'b0000);
    tick("release_idle");
    check("idle_bus", {ce_o, wr_o, addr_o, data_o}, '0);

    // Async reset while requester 2 is mid-burst.
    req = 4'b0100;
    tick("burst_gnt");
    check("burst_owner", gnt, 4'b0100);
    ce_i[2] = 1'b1; wr_i[2] = 1'b1; a_arr[2] = 8'd3; d_arr[2] = 8'h5A;
    tick("burst_wr");
    check("burst_ce", {ce_o, wr_o}, 2'b11);
    #2 rst = 1'b1;
    #1;
    check("async_rst_out", {gnt, ce_o, wr_o, err_cnt}, '0);
    @(posedge clk);
    #1;
    quiet_inputs();
    req = 4'b0101;
    #2 rst = 1'b0;
    model_reset();
    tick("post_rst");
    check("post_rst_prio", gnt, 4'b0001);
    req = '0;
    tick("post_rst_rel");
    tick("post_rst_idle");

    // Contention: every owner releases after 3 cycles; order 0,1,2,3,0 with no gaps.
    do_reset();
    req = 4'b1111;
    tick("cont_first");
    for (int k = 0; k < 5; k++) begin
      int ow;
      ow = k % N;
      for (int c = 0; c < 3; c++) begin
        check($sformatf("cont_owner%0d", k), gnt, 4'b0001 << ow);
        if (c == 2) req[ow] = 1'b0;
        tick("cont");
        if (c == 2) req[ow] = 1'b1;
      end
    end
    check("cont_after", gnt, 4'b0010);
    req = '0;
    tick("cont_rel");
    tick("cont_idle");

    // Preemption: lone owner keeps the bus indefinitely.
    req = 4'b0010;
    tick("lone");
    for (int i = 0; i < 10; i++) begin
      tick("lone_hold");
      check("lone_kept", {gnt, preempt}, {4'b0010, 1'b0});
    end
    req = 4'b0110;
    tick("late_waiter");
    check("late_preempt", {gnt, preempt}, {4'b0100, 1'b1});
    req = '0;
    tick("pre_rel");
    tick("pre_idle");

    // Preemption after exactly MH granted cycles, then the preempted owner is re-queued.
    req = 4'b0010;
    tick("hold_start");
    req = 4'b0110;
    for (int i = 0; i < 3; i++) begin
      tick("hold_wait");
      check("hold_owner1", gnt, 4'b0010);
    end
    tick("hold_expire");
    check("preempt_1to2", {gnt, preempt}, {4'b0100, 1'b1});
    tick("hold2");
    check("preempt_pulse_end", preempt, 1'b0);
    for (int i = 0; i < 2; i++) tick("hold2_wait");
    check("hold_owner2", gnt, 4'b0100);
    tick("hold2_expire");
    check("preempt_2to1", {gnt, preempt}, {4'b0010, 1'b1});
    req = '0;
    tick("hold_rel");
    tick("hold_idle");

    // Error counter saturation.
    req = 4'b0001;
    ce_i[0] = 1'b1; wr_i[0] = 1'b1; a_arr[0] = 8'hF0;
    for (int i = 0; i < 260; i++) tick("sat");
    check("err_cnt_sat", {range_err, err_cnt}, {1'b1, 8'd255});
    quiet_inputs();
    tick("sat_rel");
    tick("sat_idle");

    // Random traffic against the model.
    for (int cyc = 0; cyc < 600; cyc++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 9) < 3) req[i] = ~req[i];
        ce_i[i] = req[i] & 1'($urandom_range(0, 1));
        wr_i[i] = 1'($urandom_range(0, 1));
        a_arr[i] = 8'($urandom_range(0, 8));
        d_arr[i] = 8'($urandom);
      end
      tick("rand");
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/wr_bus_arbiter.md
Name: wr_bus_arbiter

Overview:
- Shares one write bus (ce/wr/addr/data) between NUM_REQ requesters using a req/gnt handshake.
- Grants are round-robin and one-hot, with a bounded hold time.
- Write addresses are checked against a [ADDR_MIN, ADDR_MAX] window; out-of-window writes are blocked and flagged.
- Sits between requester agents and the shared memory/register slave.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- ADDR_W, 8, address width
- DATA_W, 8, data width
- ADDR_MIN, 0, lowest legal write address (inclusive)
- ADDR_MAX, 255, highest legal write address (inclusive)
- MAX_HOLD, 16, cycles an owner may hold the bus while others wait; 0 disables preemption

Ports:
- clk  in  1  clock, all logic on posedge
- rst  in  1  asynchronous reset, active-high
- req  in  NUM_REQ  request per requester
- gnt  out  NUM_REQ  registered one-hot grant
- ce_i  in  NUM_REQ  chip enable per requester
- wr_i  in  NUM_REQ  write strobe per requester
- addr_i  in  NUM_REQ*ADDR_W  packed addresses, requester i at [i*ADDR_W +: ADDR_W]
- data_i  in  NUM_REQ*DATA_W  packed data, same packing
- ce_o  out  1  bus chip enable
- wr_o  out  1  bus write
- addr_o  out  ADDR_W  bus address
- data_o  out  DATA_W  bus data
- range_err  out  1  one-cycle pulse: blocked out-of-window write
- preempt  out  1  one-cycle pulse: owner forcibly released
- err_cnt  out  8  saturating count of range_err pulses

Behaviour:
- Reset (async, any time, including mid-grant):
  - gnt=0, ce_o=0, wr_o=0, addr_o=0, data_o=0, range_err=0, preempt=0, err_cnt=0.
  - State=IDLE, hold_cnt=0, rr_last=NUM_REQ-1, so requester 0 has first priority.
- FSM states: IDLE, GRANTED.
- IDLE:
  - When any req is sampled high, pick the first asserted index searching upward from rr_last+1 (modulo NUM_REQ).
  - At that edge: gnt[sel]=1, owner=sel, rr_last=sel, hold_cnt=0, state=GRANTED.
  - Latency from req to gnt is 1 cycle, so req |=> gnt holds from IDLE.
- GRANTED, bus path:
  - Each edge registers the owner's ce_i/wr_i/addr_i/data_i onto ce_o/wr_o/addr_o/data_o, giving 1-cycle bus latency.
  - Non-owner ce_i/wr_i/addr_i/data_i are ignored.
  - If owner ce_i&wr_i and addr is outside [ADDR_MIN, ADDR_MAX]:
    - ce_o=0, wr_o=0; addr_o/data_o are still registered.
    - range_err=1 for one cycle; err_cnt increments and saturates at 255.
  - ce_i&!wr_i (read) passes through unchecked.
  - Bounds are inclusive: ADDR_MIN and ADDR_MAX are both legal.
- GRANTED, release:
  - When req[owner]=0 is sampled, drop gnt[owner].
  - At the same edge, re-arbitrate among the remaining reqs (zero-bubble handover), else go to IDLE.
  - gnt is never multi-hot in any cycle.
- GRANTED, hold timer:
  - hold_cnt increments each GRANTED cycle and saturates.
  - When MAX_HOLD≠0, hold_cnt≥MAX_HOLD-1 and another req is high: drop gnt[owner], preempt=1 for one cycle, grant the next requester round-robin.
  - If nobody else waits, the owner keeps the bus indefinitely.
- A preempted owner that keeps req high is re-queued normally.
- The owner must hold ce_i=0 once req drops; any ce_i in the cycle after gnt falls is ignored.
- Bus outputs go to 0 on the edge after gnt falls, unless a new owner is granted at that edge.

Decomposition:
- Package wr_bus_arb_pkg: state enum {IDLE, GRANTED}, ERR_CNT_W=8, owner index type sized $clog2(NUM_REQ) via parameterised helper.
- Sub-module rr_picker: combinational round-robin search.
  - Inputs: req vector, rr_last.
  - Outputs: valid, sel index.
  - Reused by the IDLE, release and preempt paths.

Test Plan:
- Single requester: req[0]↑ at cycle 1 → gnt=4'b0001 at cycle 2. Writes addr 0..9 with ADDR_MIN=1, ADDR_MAX=5 → ce_o/wr_o for addrs 1..5 only; range_err pulses for 0 and 6..9; err_cnt=5.
- Contention: req=4'b1111 held, each owner releases after 3 cycles → grant order 0,1,2,3,0; gnt always one-hot; no idle cycle between owners.
- Preemption: MAX_HOLD=4, req[1] held forever, req[2]↑ during grant → gnt[1] falls after 4 GRANTED cycles, preempt pulse, gnt=4'b0100. With no other waiter, gnt[1] is never dropped.
- Boundaries: write addr=ADDR_MIN and addr=ADDR_MAX → both pass. err_cnt forced past 255 → holds 255.
- Async reset mid-burst: assert rst between edges while gnt[2]=1 → gnt, ce_o, wr_o immediately 0. After release, req=4'b0101 → gnt[0] first.
- Read passthrough: owner ce_i=1, wr_i=0, addr=200 with window 1..5 → ce_o=1, wr_o=0, no range_err.
